// File: rtl/alu_pkg.sv
// Shared types for the ALU issue arbiter: opcodes, FSM states
// and the multiply opcode constant.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00001,
    OP_SUB    = 5'b00010,
    OP_MUL    = 5'b00011,
    OP_AND    = 5'b01001,
    OP_OR     = 5'b01010,
    OP_XOR    = 5'b01011,
    OP_PASS_A = 5'b10001,
    OP_PASS_B = 5'b10010
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic [4:0] MUL_OPCODE = OP_MUL;

  function automatic logic op_is_mul(input logic [4:0] op);
    return op == MUL_OPCODE;
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_alu.sv
// Combinational lane-wise vector ALU shared by all requesters.
// Unknown opcodes yield zero data and raise err_o.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 4
) (
  input  logic [4:0]                             op_i,
  input  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] a_i,
  input  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] b_i,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] res_o,
  output logic                                   err_o
);

  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      case (op_i)
        OP_ADD:    res_o[i] = a_i[i] + b_i[i];
        OP_SUB:    res_o[i] = a_i[i] - b_i[i];
        OP_MUL:    res_o[i] = a_i[i] * b_i[i];
        OP_AND:    res_o[i] = a_i[i] & b_i[i];
        OP_OR:     res_o[i] = a_i[i] | b_i[i];
        OP_XOR:    res_o[i] = a_i[i] ^ b_i[i];
        OP_PASS_A: res_o[i] = a_i[i];
        OP_PASS_B: res_o[i] = b_i[i];
        default:   err_o    = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter in front of one shared vector ALU.
// One op in flight: IDLE accepts, EXEC computes, DONE holds result.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 4,
  parameter int NUM_REQ     = 4,
  parameter int MUL_CYCLES  = 3,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                                i_clk,
  input  logic                                                i_rst,
  input  logic [NUM_REQ-1:0]                                  i_req_valid,
  input  logic [NUM_REQ-1:0][4:0]                             i_req_opcode,
  input  logic [NUM_REQ-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] i_req_b,
  output logic [NUM_REQ-1:0]                                  o_req_ready,
  output logic                                                o_res_valid,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              o_res_data,
  output logic [ID_W-1:0]                                     o_res_id,
  output logic                                                o_res_err,
  input  logic                                                i_res_ready,
  output logic                                                o_busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  vec_t             a_q, a_d;
  vec_t             b_q, b_d;
  vec_t             res_data_q, res_data_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic             res_err_q, res_err_d;

  vec_t             alu_res;
  logic             alu_err;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W:0]    sum;

  alu #(
    .DATA_WIDTH  (DATA_WIDTH),
    .VECTOR_SIZE (VECTOR_SIZE)
  ) u_alu (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (alu_res),
    .err_o (alu_err)
  );

  // First valid requester at or above rr_q, wrapping at NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ))
        sum = sum - (ID_W+1)'(NUM_REQ);
      if (!grant_vld && i_req_valid[sum[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;
    o_req_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          o_req_ready[grant_idx] = 1'b1;
          op_d    = i_req_opcode[grant_idx];
          a_d     = i_req_a[grant_idx];
          b_d     = i_req_b[grant_idx];
          id_d    = grant_idx;
          cnt_d   = op_is_mul(i_req_opcode[grant_idx]) ?
                    CNT_W'(MUL_CYCLES - 1) : '0;
          rr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ?
                    '0 : grant_idx + 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          res_data_d = alu_res;
          res_err_d  = alu_err;
          res_id_d   = id_q;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (i_res_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      res_err_q  <= res_err_d;
    end
  end

  assign o_res_valid = (state_q == ST_DONE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_res_data  = res_data_q;
  assign o_res_id    = res_id_q;
  assign o_res_err   = res_err_q;

endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, lane width in bits.
REQ-002 SHALL have parameter VECTOR_SIZE, default 4, lanes per operand.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (>=2); ID_W = $clog2(NUM_REQ).
REQ-004 SHALL have parameter MUL_CYCLES, default 3, EXEC cycles for multiply (>=1).
REQ-005 SHALL use one clock and a synchronous, active-high reset, named i_clk and i_rst (ports: i_clk in 1 clock; i_rst in 1 reset).
REQ-006 i_req_valid  in  NUM_REQ  per-requester request valid.
REQ-007 i_req_opcode  in  NUM_REQ x 5  per-requester opcode.
REQ-008 i_req_a, i_req_b  in  NUM_REQ x VECTOR_SIZE x DATA_WIDTH  per-requester operands.
REQ-009 o_req_ready  out  NUM_REQ  one-hot accept strobe.
REQ-010 o_res_valid  out  1  result available.
REQ-011 o_res_data  out  VECTOR_SIZE x DATA_WIDTH  vector result.
REQ-012 o_res_id  out  ID_W  index of the issuing requester.
REQ-013 o_res_err  out  1  opcode was unsupported.
REQ-014 i_res_ready  in  1  consumer accepts result.
REQ-015 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; no other states.
REQ-017 In IDLE, if any i_req_valid is high, SHALL assert o_req_ready for exactly one winner that cycle (combinational), latch its opcode/operands/index and enter EXEC; otherwise SHALL hold o_req_ready all zero.
REQ-018 o_req_ready SHALL be all zero in EXEC and DONE.
REQ-019 Winner SHALL be chosen round-robin: search upward from pointer rr_ptr, wrapping NUM_REQ-1 -> 0; after a grant to k, rr_ptr = (k+1) mod NUM_REQ.
REQ-020 EXEC SHALL last MUL_CYCLES cycles for opcode 5'b00011, else 1 cycle, using a down-counter loaded on accept.
REQ-021 On the last EXEC cycle, SHALL register the shared-ALU result into o_res_data, set o_res_id and o_res_err, and enter DONE.
REQ-022 Supported opcodes: 00001 ADD, 00010 SUB, 00011 MUL, 01001 AND, 01010 OR, 01011 XOR, 10001 PASS_A, 10010 PASS_B; lane-wise, results truncated to DATA_WIDTH (modulo 2^DATA_WIDTH).
REQ-023 Unsupported opcode SHALL still run a 1-cycle EXEC, produce all-zero o_res_data and o_res_err = 1.
REQ-024 In DONE, o_res_valid SHALL be 1 and o_res_data/id/err SHALL stay stable until i_res_ready; on i_res_ready SHALL return to IDLE (no same-cycle new accept).
REQ-025 Latency: accept at edge T -> o_res_valid high from cycle T+2 (non-MUL) or T+1+MUL_CYCLES (MUL); max throughput one op per 3 cycles.
REQ-026 Requesters SHALL hold valid and operands until their o_req_ready; deasserting valid before grant SHALL simply drop them from arbitration.
REQ-027 Operands SHALL be captured at accept; later input changes SHALL not affect the in-flight result.

Reset
REQ-028 On i_rst: state IDLE, rr_ptr 0, counter 0, o_res_valid 0, o_res_data 0, o_res_id 0, o_res_err 0, o_busy 0, o_req_ready all zero.
REQ-029 Reset mid-EXEC or mid-DONE SHALL discard the in-flight operation; no result SHALL appear afterwards.

Structure
REQ-030 Opcode enum, FSM state enum and MUL opcode constant SHALL live in shared package alu_pkg.
REQ-031 SHALL instantiate the existing combinational alu as its single sub-module, fed from latched operand/opcode registers.

Verification
REQ-032 Single req0 ADD a=all 5, b=all 7 -> ready0 at T, res_valid at T+2, data all 12, id 0, err 0.
REQ-033 All four valid continuously with SUB -> grants in order 0,1,2,3,0; each result id matches.
REQ-034 req2 MUL a=0x0001_0000, b=0x0001_0000, MUL_CYCLES=3 -> res_valid at T+4, data 0 (truncated), err 0.
REQ-035 Opcode 5'b11111 -> data all 0, err 1, res_valid at T+2.
REQ-036 Hold i_res_ready low 5 cycles in DONE -> outputs stable, no new ready; then ready high -> IDLE, next grant the following cycle.
REQ-037 Assert i_rst during MUL EXEC -> o_res_valid never rises; rr_ptr 0, next grant goes to lowest valid index.
